// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Frames are never interleaved; a stalled transmitter or abandoned frame is aborted by timeout.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 65535
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [7:0]                 tx_data,
    output logic                       tx_start,
    input  logic                       tx_start_clear,
    input  logic                       tx_busy,
    output logic                       grant_active,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       timeout_err
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int IDX_W = ID_W + 1;
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0]  ID_MAX   = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, START, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_q, rr_d;
    logic [ID_W-1:0]    grant_id_d;
    logic               lock_q, lock_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [7:0]         tx_data_d;
    logic               tx_start_d;
    logic               grant_active_d;
    logic               timeout_err_d;
    logic               abort;

    logic [NUM_REQ-1:0] cand;
    logic [IDX_W-1:0]   idx;
    logic               found;
    logic [ID_W-1:0]    win;
    logic [7:0]         win_data;

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (id == ID_MAX) ? '0 : id + ID_W'(1);
    endfunction

    // While a frame is locked only its owner may compete; otherwise search upward from the rr pointer.
    always_comb begin
        cand  = lock_q ? (req_valid & (NUM_REQ'(1) << grant_id)) : req_valid;
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_q} + IDX_W'(k);
            if (idx >= IDX_W'(NUM_REQ)) begin
                idx = idx - IDX_W'(NUM_REQ);
            end
            if (!found && cand[idx[ID_W-1:0]]) begin
                found = 1'b1;
                win   = idx[ID_W-1:0];
            end
        end
        win_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win == ID_W'(k)) begin
                win_data = req_data[8*k +: 8];
            end
        end
    end

    assign abort = (timer_q == TMR_LAST);

    always_comb begin
        state_d        = state_q;
        rr_d           = rr_q;
        grant_id_d     = grant_id;
        lock_d         = lock_q;
        timer_d        = timer_q;
        tx_data_d      = tx_data;
        tx_start_d     = tx_start;
        grant_active_d = grant_active;
        timeout_err_d  = 1'b0;
        req_ready      = '0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    req_ready[win] = rst_n;
                    tx_data_d      = win_data;
                    tx_start_d     = 1'b1;
                    grant_id_d     = win;
                    grant_active_d = 1'b1;
                    lock_d         = ~req_last[win];
                    timer_d        = '0;
                    state_d        = START;
                    if (req_last[win]) begin
                        rr_d = next_id(win);
                    end
                end else if (lock_q) begin
                    // Owner went quiet mid-frame: give up on it after the timeout.
                    if (abort) begin
                        timeout_err_d  = 1'b1;
                        lock_d         = 1'b0;
                        grant_active_d = 1'b0;
                        rr_d           = next_id(grant_id);
                        timer_d        = '0;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end else begin
                    timer_d = '0;
                end
            end
            START: begin
                if (tx_start_clear) begin
                    tx_start_d = 1'b0;
                    timer_d    = '0;
                    state_d    = DRAIN;
                end else if (abort) begin
                    tx_start_d     = 1'b0;
                    timeout_err_d  = 1'b1;
                    lock_d         = 1'b0;
                    grant_active_d = 1'b0;
                    rr_d           = next_id(grant_id);
                    timer_d        = '0;
                    state_d        = IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            DRAIN: begin
                timer_d = '0;
                if (!tx_busy) begin
                    grant_active_d = lock_q;
                    state_d        = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_q         <= '0;
            grant_id     <= '0;
            lock_q       <= 1'b0;
            timer_q      <= '0;
            tx_data      <= '0;
            tx_start     <= 1'b0;
            grant_active <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            grant_id     <= grant_id_d;
            lock_q       <= lock_d;
            timer_q      <= timer_d;
            tx_data      <= tx_data_d;
            tx_start     <= tx_start_d;
            grant_active <= grant_active_d;
            timeout_err  <= timeout_err_d;
        end
    end

endmodule
